fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter W, default `WORD_WIDTH (32), meaning address and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 32'hBFC0_0000, meaning the first fetch address after reset.
REQ-003 SHALL have parameter DEPTH, default 4, power of two >=2, meaning instruction buffer entries and maximum in-flight requests.
REQ-004 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have imem_req_valid  output  1, imem_req_ready  input  1, imem_addr  output  W, forming the request channel.
REQ-007 SHALL have imem_resp_valid  input  1, imem_resp_data  input  W, forming the response channel: in order, no backpressure.
REQ-008 SHALL have redirect_en  input  1 and redirect_pc  input  W, meaning a branch or jump target taken this cycle.
REQ-009 SHALL have inst_valid  output  1, inst_ready  input  1, inst  output  W, inst_pc  output  W, forming the downstream channel.
REQ-010 SHALL have busy  output  1, meaning fetch state is RUN.

Function
REQ-011 SHALL keep fetch_pc and issue imem_req_valid=1 with imem_addr=fetch_pc in RUN when in_flight+buf_count < DEPTH.
REQ-012 SHALL treat a request as accepted when valid&ready, then set fetch_pc+=4 with modulo 2^W wrap and increment in_flight.
REQ-013 SHALL push {fetch address, data} into the buffer on a non-dropped response and decrement in_flight; the buffer can never overflow because of credit (REQ-011).
REQ-014 SHALL present the buffer head on inst/inst_pc with inst_valid=!empty, and pop when inst_valid&inst_ready.
REQ-015 SHALL support a simultaneous push and pop in one cycle, including when full or empty (empty push: valid next cycle, one-cycle latency response->inst_valid).
REQ-016 SHALL, on redirect_en: clear the buffer, set fetch_pc=redirect_pc, set drop_cnt=in_flight (including a request accepted and a response arriving in the same cycle), and enter DRAIN if that count is non-zero, else stay in RUN.
REQ-017 SHALL, in DRAIN, issue no requests, discard each response while decrementing drop_cnt, and return to RUN the cycle after drop_cnt reaches 0.
REQ-018 SHALL honour a pop coinciding with redirect_en as consumed, while the buffer still empties.
REQ-019 SHALL let a redirect during DRAIN replace fetch_pc and keep counting the remaining outstanding responses.
REQ-020 SHALL only compare redirect_pc as given; misaligned targets are fetched unchanged.

Reset
REQ-021 SHALL on rst low immediately set fetch_pc=RESET_PC, state=RUN, in_flight=0, drop_cnt=0, buffer empty, imem_req_valid=0, inst_valid=0, busy=0; first request issues the cycle after rst deasserts.
REQ-022 SHALL discard, after reset mid-operation, responses to pre-reset requests; integration guarantees memory is reset alongside.

Configuration
REQ-023 SHALL, with FETCH_STATS_EN defined, add outputs stat_fetched (W, popped instructions) and stat_dropped (W, discarded responses plus flushed buffer entries), both wrapping and reset to 0.
REQ-024 SHALL, without FETCH_STATS_EN, have neither the ports nor the counters.

Structure
REQ-025 SHALL take WORD_WIDTH, the default RESET_PC and the FSM state encodings (RUN, DRAIN) from the shared defines.v.
REQ-026 SHALL implement the buffer as sub-module fetch_fifo (parameters W2=2W, DEPTH; push, pop, flush, full, empty, count).

Verification
REQ-027 SHALL cover: reset, imem_req_ready=1, 1-cycle response -> addresses BFC00000, BFC00004, BFC00008 in order; inst_pc matches.
REQ-028 SHALL cover: inst_ready=0 -> exactly 4 requests issued then imem_req_valid=0; raising inst_ready resumes.
REQ-029 SHALL cover: redirect_en to 0x80001000 with 3 in flight -> 3 responses discarded, busy=0 for those cycles, next inst_pc=0x80001000.
REQ-030 SHALL cover: redirect coinciding with a response and a pop -> the popped instruction is counted, the response is dropped, and with FETCH_STATS_EN stat_dropped increases accordingly.
REQ-031 SHALL cover: fetch_pc=FFFFFFFC -> next address 00000000.
REQ-032 SHALL cover: rst asserted mid-DRAIN -> all outputs reach reset values asynchronously, next fetch at BFC00000.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word width, the default
// reset PC and the fetch FSM state encodings.
package fetch_unit_pkg;

    localparam int unsigned WORD_WIDTH       = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of W2-bit entries with synchronous flush.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   push, push_data      write an entry (ignored when full unless popping)
//   pop                  drop the head entry (ignored when empty)
//   flush                discard every entry; wins over push/pop
//   head_data            current head entry
//   full, empty, count   occupancy
module fetch_fifo #(
    parameter int unsigned W2    = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W2-1:0]              push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W2-1:0]              head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W2-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

    // Pointers and occupancy; pointer wrap relies on DEPTH being a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array, no reset needed: contents are qualified by cnt.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];
    assign full      = (cnt == CW'(DEPTH));
    assign empty     = (cnt == '0);
    assign count     = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches under a credit limit,
// buffers in-order responses and hands them downstream; a redirect flushes
// the buffer and drains responses to requests that are no longer wanted.
// Optional macro FETCH_STATS_EN adds stat_fetched / stat_dropped counters.
// Ports:
//   clk, rst                                    clock, async active-low reset
//   imem_req_valid/ready, imem_addr             fetch request channel
//   imem_resp_valid, imem_resp_data             in-order response, no backpressure
//   redirect_en, redirect_pc                    taken branch/jump target
//   inst_valid/ready, inst, inst_pc             downstream instruction channel
//   busy                                        fetch FSM is in RUN
//   stat_fetched, stat_dropped (FETCH_STATS_EN) popped / discarded counts
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned  W        = WORD_WIDTH,
    parameter logic [W-1:0] RESET_PC = W'(RESET_PC_DEFAULT),
    parameter int unsigned  DEPTH    = 4
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req_valid,
    input  logic         imem_req_ready,
    output logic [W-1:0] imem_addr,
    input  logic         imem_resp_valid,
    input  logic [W-1:0] imem_resp_data,
    input  logic         redirect_en,
    input  logic [W-1:0] redirect_pc,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [W-1:0] inst,
    output logic [W-1:0] inst_pc,
    output logic         busy
`ifdef FETCH_STATS_EN
    ,
    output logic [W-1:0] stat_fetched,
    output logic [W-1:0] stat_dropped
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = CW + 1;

    fetch_state_e   state_q;
    fetch_state_e   state_d;
    logic [W-1:0]   fetch_pc_q;
    logic [W-1:0]   fetch_pc_d;
    logic [W-1:0]   resp_pc_q;
    logic [W-1:0]   resp_pc_d;
    logic [CW-1:0]  in_flight_q;
    logic [CW-1:0]  in_flight_d;
    logic [CW-1:0]  drop_q;
    logic [CW-1:0]  drop_d;
    logic [CW-1:0]  fifo_count;
    logic [CW-1:0]  count_d;
    logic [SW-1:0]  outstanding;
    logic           req_valid_d;
    logic           busy_d;
    logic           accept;
    logic           resp_live;
    logic           resp_drop;
    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [2*W-1:0] head;

    assign accept    = imem_req_valid && imem_req_ready;
    assign resp_live = imem_resp_valid && (drop_q == '0) && (in_flight_q != '0);
    assign resp_drop = imem_resp_valid && (drop_q != '0);
    assign pop       = !fifo_empty && inst_ready;
    assign push      = resp_live && !redirect_en && (!fifo_full || pop);
    // Everything still owed by memory after this edge, counted before a redirect kills it.
    assign outstanding = SW'(drop_q) + SW'(in_flight_q) + SW'(accept)
                       - SW'(resp_live || resp_drop);

    // Live responses are sequential from resp_pc, so their address needs no queue.
    fetch_fifo #(
        .W2    (2 * W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({resp_pc_q, imem_resp_data}),
        .pop       (pop),
        .flush     (redirect_en),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    // Next state: a redirect decides from the new drop count; DRAIN leaves once it is spent.
    always_comb begin
        state_d = state_q;
        if (redirect_en) begin
            state_d = (drop_d != '0) ? DRAIN : RUN;
        end else if (state_q == DRAIN && drop_q == '0) begin
            state_d = RUN;
        end
    end

    // Next values of the registered outputs, taken from post-edge occupancy.
    always_comb begin
        busy_d      = (state_d == RUN);
        req_valid_d = (state_d == RUN)
                   && ((SW'(in_flight_d) + SW'(count_d)) < SW'(DEPTH));
    end

    // Datapath next-state.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        resp_pc_d   = resp_pc_q;
        in_flight_d = in_flight_q;
        drop_d      = drop_q;
        count_d     = fifo_count + CW'(push) - CW'(pop);
        if (redirect_en) begin
            fetch_pc_d  = redirect_pc;
            resp_pc_d   = redirect_pc;
            in_flight_d = '0;
            drop_d      = CW'(outstanding);
            count_d     = '0;
        end else begin
            if (accept) fetch_pc_d = fetch_pc_q + W'(4);
            if (push)   resp_pc_d  = resp_pc_q + W'(4);
            in_flight_d = in_flight_q + CW'(accept) - CW'(resp_live);
            drop_d      = drop_q - CW'(resp_drop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q     <= RESET_PC;
            resp_pc_q      <= RESET_PC;
            in_flight_q    <= '0;
            drop_q         <= '0;
            imem_req_valid <= 1'b0;
            busy           <= 1'b0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            resp_pc_q      <= resp_pc_d;
            in_flight_q    <= in_flight_d;
            drop_q         <= drop_d;
            imem_req_valid <= req_valid_d;
            busy           <= busy_d;
        end
    end

    assign imem_addr  = fetch_pc_q;
    assign inst_valid = !fifo_empty;
    assign inst_pc    = head[2*W-1:W];
    assign inst       = head[W-1:0];

`ifdef FETCH_STATS_EN
    // Dropped = discarded responses plus entries flushed (a same-cycle pop counts as fetched).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            stat_fetched <= stat_fetched + W'(pop);
            stat_dropped <= stat_dropped + W'(resp_drop || (redirect_en && resp_live))
                          + (redirect_en ? W'(fifo_count - CW'(pop)) : '0);
        end
    end
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory with random latency,
// a transaction-level reference model (request/buffer queues with live/dead
// tags), directed scenarios followed by a randomized phase.
module tb_fetch_unit;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic         clk;
    logic         rst;
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [W-1:0] imem_addr;
    logic         imem_resp_valid;
    logic [W-1:0] imem_resp_data;
    logic         redirect_en;
    logic [W-1:0] redirect_pc;
    logic         inst_valid;
    logic         inst_ready;
    logic [W-1:0] inst;
    logic [W-1:0] inst_pc;
    logic         busy;
`ifdef FETCH_STATS_EN
    logic [W-1:0] stat_fetched;
    logic [W-1:0] stat_dropped;
`endif

    fetch_unit #(
        .W        (W),
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_en     (redirect_en),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .busy            (busy)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched    (stat_fetched),
        .stat_dropped    (stat_dropped)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          live;
    } req_t;

    req_t        mem_q[$];
    logic [31:0] m_buf[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] m_fetch_pc;
    logic [31:0] m_fetched;
    logic [31:0] m_dropped;
    bit          m_drain;
    bit          m_fresh;
    int          cyc;
    int          lat_min;
    int          lat_max;
    int          n_cmp;
    int          n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (mem_q[i]) if (mem_q[i].live) n++;
        return n;
    endfunction

    function automatic int dead_cnt();
        int n = 0;
        foreach (mem_q[i]) if (!mem_q[i].live) n++;
        return n;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    // Asynchronous reset away from any clock edge; memory is reset alongside.
    task automatic do_reset();
        #2;
        rst             = 1'b0;
        imem_req_ready  = 1'b0;
        inst_ready      = 1'b0;
        redirect_en     = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        #1;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", imem_addr, RST_PC);
`ifdef FETCH_STATS_EN
        check("rst_stat_fetched", stat_fetched, 0);
        check("rst_stat_dropped", stat_dropped, 0);
`endif
        mem_q.delete();
        m_buf.delete();
        acc_log.delete();
        pop_log.delete();
        m_fetch_pc = RST_PC;
        m_fetched  = '0;
        m_dropped  = '0;
        m_drain    = 1'b0;
        m_fresh    = 1'b1;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input bit rdy, input bit irdy, input bit redir, input logic [31:0] rpc);
        bit   acc;
        bit   pop;
        bit   resp;
        int   pre_dead;
        int   due;
        req_t h;
        check("req_valid", imem_req_valid,
              !m_drain && !m_fresh && (live_cnt() + m_buf.size() < DEPTH));
        check("busy", busy, !m_drain && !m_fresh);
        check("inst_valid", inst_valid, m_buf.size() != 0);
        if (m_buf.size() != 0) begin
            check("inst_pc", inst_pc, m_buf[0]);
            check("inst", inst, mem_word(m_buf[0]));
        end
`ifdef FETCH_STATS_EN
        check("stat_fetched", stat_fetched, m_fetched);
        check("stat_dropped", stat_dropped, m_dropped);
`endif
        imem_req_ready = rdy;
        inst_ready     = irdy;
        redirect_en    = redir;
        redirect_pc    = rpc;
        resp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp;
        imem_resp_data  = resp ? mem_word(mem_q[0].addr) : $urandom;
        acc = imem_req_valid && rdy;
        pop = inst_valid && irdy;
        if (acc) begin
            check("imem_addr", imem_addr, m_fetch_pc);
            acc_log.push_back(imem_addr);
        end
        pre_dead = dead_cnt();
        if (pop && m_buf.size() != 0) begin
            pop_log.push_back(m_buf[0]);
            void'(m_buf.pop_front());
            m_fetched++;
        end
        if (resp) begin
            h = mem_q.pop_front();
            if (h.live && !redir) m_buf.push_back(h.addr);
            else                  m_dropped++;
        end
        if (acc) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (mem_q.size() != 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
            mem_q.push_back('{addr: m_fetch_pc, due: due, live: 1'b1});
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redir) begin
            foreach (mem_q[i]) mem_q[i].live = 1'b0;
            m_dropped  = m_dropped + 32'(m_buf.size());
            m_buf.delete();
            m_fetch_pc = rpc;
            m_drain    = dead_cnt() != 0;
        end else if (m_drain && pre_dead == 0) begin
            m_drain = 1'b0;
        end
        m_fresh = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit          hit;
        int          mark;
        logic [31:0] rpc;
        n_cmp           = 0;
        n_err           = 0;
        cyc             = 0;
        lat_min         = 1;
        lat_max         = 1;
        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        inst_ready      = 1'b0;
        redirect_en     = 1'b0;
        redirect_pc     = '0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        @(negedge clk);
        do_reset();

        // Sequential fetch, 1-cycle memory.
        for (int k = 0; k < 10; k++) step(1, 1, 0, 0);
        check("seq_addr0", acc_at(0), 32'hBFC0_0000);
        check("seq_addr1", acc_at(1), 32'hBFC0_0004);
        check("seq_addr2", acc_at(2), 32'hBFC0_0008);
        check("seq_pc0", pop_at(0), 32'hBFC0_0000);
        check("seq_pc1", pop_at(1), 32'hBFC0_0004);
        check("seq_pc2", pop_at(2), 32'hBFC0_0008);

        // Stalled consumer: credit stops issue at DEPTH, then resumes.
        do_reset();
        for (int k = 0; k < 15; k++) step(1, 0, 0, 0);
        check("credit_reqs", acc_log.size(), 4);
        check("credit_stall", imem_req_valid, 0);
        for (int k = 0; k < 10; k++) step(1, 1, 0, 0);
        check("credit_resume", acc_log.size() > 4, 1);

        // Redirect with three requests in flight.
        do_reset();
        lat_min = 6;
        lat_max = 6;
        for (int k = 0; k < 20 && live_cnt() != 3; k++) step(1, 1, 0, 0);
        check("inflight3", live_cnt(), 3);
        step(0, 1, 1, 32'h8000_1000);
        check("drain_busy", busy, 0);
        check("drain_no_req", imem_req_valid, 0);
        mark = pop_log.size();
        for (int k = 0; k < 40 && pop_log.size() == mark; k++) step(1, 1, 0, 0);
        check("redir_pc", pop_at(mark), 32'h8000_1000);

        // Redirect coinciding with a live response and a pop.
        lat_min = 2;
        lat_max = 2;
        hit     = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (inst_valid && m_buf.size() != 0 && mem_q.size() != 0
                && mem_q[0].due <= cyc && mem_q[0].live) begin
                hit = 1'b1;
                step(1, 1, 1, 32'h0000_2000);
                check("coincide_flush", inst_valid, 0);
            end else begin
                step(1, $urandom_range(1, 0), 0, 0);
            end
        end
        check("coincide_hit", hit, 1);
        mark = pop_log.size();
        for (int k = 0; k < 40 && pop_log.size() == mark; k++) step(1, 1, 0, 0);
        check("coincide_next_pc", pop_at(mark), 32'h0000_2000);

        // Address wrap at the top of the space.
        lat_min = 1;
        lat_max = 1;
        step(0, 1, 1, 32'hFFFF_FFF8);
        acc_log.delete();
        for (int k = 0; k < 12; k++) step(1, 1, 0, 0);
        check("wrap_addr0", acc_at(0), 32'hFFFF_FFF8);
        check("wrap_addr1", acc_at(1), 32'hFFFF_FFFC);
        check("wrap_addr2", acc_at(2), 32'h0000_0000);

        // Reset while draining.
        lat_min = 8;
        lat_max = 8;
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
        step(0, 1, 1, 32'h4000_0000);
        check("pre_rst_drain", busy, 0);
        do_reset();
        lat_min = 1;
        lat_max = 1;
        for (int k = 0; k < 4; k++) step(1, 1, 0, 0);
        check("post_rst_addr", acc_at(0), RST_PC);

        // Randomized traffic with random latency and redirect targets.
        lat_min = 1;
        lat_max = 5;
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(3, 0))
                0:       rpc = $urandom & 32'hFFFF_FFFC;
                1:       rpc = $urandom;
                2:       rpc = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000C);
                default: rpc = 32'h8000_0000 + ($urandom & 32'h0000_0FFC);
            endcase
            step($urandom_range(3, 0) != 0, $urandom_range(2, 0) != 0,
                 $urandom_range(19, 0) == 0, rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
